// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default frame width.
// Pure declarations; no timing, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam int PAR_NONE      = 0;
  localparam int PAR_ODD       = 1;
  localparam int PAR_EVEN      = 2;
  localparam int DATA_BITS_DEF = 8;

  // x is the XOR of all data bits and the received parity bit.
  function automatic logic par_error(input int mode, input logic x);
    if (mode == PAR_ODD)  return ~x;
    if (mode == PAR_EVEN) return x;
    return 1'b0;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; 2 clk latency, reset to RST_VAL.
// No flow control; output follows the input continuously.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start detect, mid-bit sampling on clk_bps, byte + error flags as a 1-clk strobe.
// bps_start rises 3 clk after rxd falls; rx_valid 1 clk after the stop tick; no backpressure.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 w_rxd;
  logic                 w_fall;
  logic                 r_hist;
  logic [1:0]           r_flush;
  logic                 r_armed;
  state_t               r_state;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_bps_start;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;

  rx_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rxd),
    .o_sync  (w_rxd)
  );

  // The synchronizer shows its reset value for two clocks after release, so a line
  // held low through reset must be seen high once before any edge is believed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= 1'b1;
      r_flush <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_hist  <= w_rxd;
      r_flush <= {r_flush[0], 1'b1};
      if (r_flush[1] && w_rxd) r_armed <= 1'b1;
    end
  end

  assign w_fall = r_armed & r_hist & ~w_rxd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_bps_start  <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_bps_start <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_par_err   <= 1'b0;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          if (clk_bps) begin
            if (w_rxd) begin
              r_bps_start <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (clk_bps) begin
            r_shift   <= {w_rxd, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) r_state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end
        end
        ST_PAR: begin
          if (clk_bps) begin
            r_par_err <= par_error(PARITY, (^r_shift) ^ w_rxd);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (clk_bps) begin
            r_bps_start  <= 1'b0;
            r_rx_data    <= r_shift;
            r_rx_valid   <= 1'b1;
            r_frame_err  <= ~w_rxd;
            r_parity_err <= r_par_err;
            r_state      <= w_rxd ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (w_rxd) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bps_start  = r_bps_start;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign rx_busy    = (r_state != ST_IDLE);

endmodule
